// File: rtl/synth_pkg.sv
// Shared encodings for the voice allocator: waveform select, command word
// field positions, special note numbers and the controller state type.
package synth_pkg;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_SAW    = 2'd2,
    WAVE_TRI    = 2'd3
  } wave_t;

  localparam int unsigned CMD_ON_BIT   = 15;
  localparam int unsigned CMD_NOTE_LSB = 8;
  localparam int unsigned CMD_NOTE_W   = 7;
  localparam int unsigned CMD_VEL_LSB  = 0;
  localparam int unsigned CMD_VEL_W    = 8;

  localparam logic [CMD_NOTE_W-1:0] NOTE_CMD_WAVE = 7'd0;
  localparam logic [CMD_NOTE_W-1:0] NOTE_STOP_ALL = 7'd127;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_APPLY = 2'd2
  } state_t;

  function automatic wave_t next_wave(input wave_t w);
    return wave_t'(w + 2'd1);
  endfunction

endpackage

// File: rtl/voice_allocator_if.sv
// Avalon-MM slave port of the voice allocator: command writes and status reads.
interface voice_allocator_if;
  logic        avs_s0_write;
  logic [31:0] avs_s0_writedata;
  logic        avs_s0_waitrequest;
  logic        avs_s0_read;
  logic [31:0] avs_s0_readdata;

  modport master (
    output avs_s0_write, avs_s0_writedata, avs_s0_read,
    input  avs_s0_waitrequest, avs_s0_readdata
  );

  modport slave (
    input  avs_s0_write, avs_s0_writedata, avs_s0_read,
    output avs_s0_waitrequest, avs_s0_readdata
  );
endinterface

// File: rtl/voice_slot.sv
// One polyphony slot: holds note, velocity, playing flag and a saturating age.
module voice_slot #(
  parameter int unsigned NOTE_W  = 7,
  parameter int unsigned VEL_W   = 8,
  parameter int unsigned AGE_W   = 4,
  parameter int unsigned AGE_MAX = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              rel,
  input  logic              age_inc,
  input  logic [NOTE_W-1:0] note_in,
  input  logic [VEL_W-1:0]  vel_in,
  output logic              active,
  output logic [NOTE_W-1:0] note,
  output logic [VEL_W-1:0]  velocity,
  output logic [AGE_W-1:0]  age
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active   <= 1'b0;
      note     <= '0;
      velocity <= '0;
      age      <= '0;
    end else if (load) begin
      active   <= 1'b1;
      note     <= note_in;
      velocity <= vel_in;
      age      <= '0;
    end else if (rel) begin
      active <= 1'b0;
    end else if (age_inc && (age != AGE_W'(AGE_MAX))) begin
      age <= age + 1'b1;
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: Avalon-MM note commands are resolved by a
// one-voice-per-cycle scan, then applied to the slot array in a single cycle.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 10,
  parameter int unsigned NOTE_W     = 7,
  parameter int unsigned VEL_W      = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  voice_allocator_if.slave             avs,
  output logic [NUM_VOICES-1:0]        o_voice_active,
  output logic [NUM_VOICES*NOTE_W-1:0] o_voice_note,
  output logic [NUM_VOICES*VEL_W-1:0]  o_voice_velocity,
  output logic [NUM_VOICES-1:0]        o_voice_start,
  output logic [NUM_VOICES-1:0]        o_voice_stop,
  output logic [1:0]                   o_wave_sel
);

  localparam int unsigned IDX_W = $clog2(NUM_VOICES);
  localparam int unsigned AGE_W = IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  state_t state, state_next;
  wave_t  wave_sel;

  logic                  cmd_on;
  logic [CMD_NOTE_W-1:0] cmd_note;
  logic [CMD_VEL_W-1:0]  cmd_vel;

  logic [IDX_W-1:0] scan_idx, match_idx, free_idx, oldest_idx, target_idx;
  logic             match_found, free_found;
  logic [AGE_W-1:0] oldest_age;

  logic [NOTE_W-1:0] slot_note [NUM_VOICES];
  logic [VEL_W-1:0]  slot_vel  [NUM_VOICES];
  logic [AGE_W-1:0]  slot_age  [NUM_VOICES];
  logic [NUM_VOICES-1:0] slot_active, load_vec, rel_vec, inc_vec, start_vec, stop_vec;

  logic       wave_adv, accept;
  logic [7:0] active_count;
  logic       unused_hi;

  assign accept                 = avs.avs_s0_write && (state == ST_IDLE);
  assign avs.avs_s0_waitrequest = (state != ST_IDLE);
  assign unused_hi              = ^avs.avs_s0_writedata[31:16];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Scan results accumulate across SCAN cycles; the first hit wins for match
  // and free slot, and a strict '>' keeps the lowest index on equal ages.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_on      <= 1'b0;
      cmd_note    <= '0;
      cmd_vel     <= '0;
      scan_idx    <= '0;
      match_found <= 1'b0;
      match_idx   <= '0;
      free_found  <= 1'b0;
      free_idx    <= '0;
      oldest_idx  <= '0;
      oldest_age  <= '0;
    end else if (accept) begin
      cmd_on      <= avs.avs_s0_writedata[CMD_ON_BIT];
      cmd_note    <= avs.avs_s0_writedata[CMD_NOTE_LSB +: CMD_NOTE_W];
      cmd_vel     <= avs.avs_s0_writedata[CMD_VEL_LSB +: CMD_VEL_W];
      scan_idx    <= '0;
      match_found <= 1'b0;
      match_idx   <= '0;
      free_found  <= 1'b0;
      free_idx    <= '0;
      oldest_idx  <= '0;
      oldest_age  <= '0;
    end else if (state == ST_SCAN) begin
      if (scan_idx != LAST_IDX) scan_idx <= scan_idx + 1'b1;
      if (slot_active[scan_idx] && (slot_note[scan_idx] == NOTE_W'(cmd_note)) && !match_found) begin
        match_found <= 1'b1;
        match_idx   <= scan_idx;
      end
      if (!slot_active[scan_idx] && !free_found) begin
        free_found <= 1'b1;
        free_idx   <= scan_idx;
      end
      if (slot_active[scan_idx] && (slot_age[scan_idx] > oldest_age)) begin
        oldest_age <= slot_age[scan_idx];
        oldest_idx <= scan_idx;
      end
    end
  end

  always_comb begin
    state_next = state;
    load_vec   = '0;
    rel_vec    = '0;
    inc_vec    = '0;
    start_vec  = '0;
    stop_vec   = '0;
    wave_adv   = 1'b0;
    target_idx = '0;
    case (state)
      ST_IDLE:  if (avs.avs_s0_write) state_next = ST_SCAN;
      ST_SCAN:  if (scan_idx == LAST_IDX) state_next = ST_APPLY;
      ST_APPLY: begin
        state_next = ST_IDLE;
        if (cmd_on) begin
          if (cmd_note == NOTE_CMD_WAVE) begin
            wave_adv = 1'b1;
          end else if (cmd_note != NOTE_STOP_ALL) begin
            if (match_found)     target_idx = match_idx;
            else if (free_found) target_idx = free_idx;
            else                 target_idx = oldest_idx;
            load_vec[target_idx]  = 1'b1;
            start_vec[target_idx] = 1'b1;
            inc_vec = slot_active & ~load_vec;
          end
        end else if (cmd_note == NOTE_STOP_ALL) begin
          rel_vec  = slot_active;
          stop_vec = slot_active;
        end else if ((cmd_note != NOTE_CMD_WAVE) && match_found) begin
          rel_vec[match_idx]  = 1'b1;
          stop_vec[match_idx] = 1'b1;
        end
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_slot
    voice_slot #(
      .NOTE_W (NOTE_W),
      .VEL_W  (VEL_W),
      .AGE_W  (AGE_W),
      .AGE_MAX(NUM_VOICES - 1)
    ) u_slot (
      .clk     (clk),
      .reset   (reset),
      .load    (load_vec[v]),
      .rel     (rel_vec[v]),
      .age_inc (inc_vec[v]),
      .note_in (NOTE_W'(cmd_note)),
      .vel_in  (VEL_W'(cmd_vel)),
      .active  (slot_active[v]),
      .note    (slot_note[v]),
      .velocity(slot_vel[v]),
      .age     (slot_age[v])
    );
    assign o_voice_note[v*NOTE_W +: NOTE_W]    = slot_note[v];
    assign o_voice_velocity[v*VEL_W +: VEL_W]  = slot_vel[v];
  end

  assign o_voice_active = slot_active;
  assign o_wave_sel     = wave_sel;

  always_comb begin
    active_count = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++)
      active_count = active_count + 8'(slot_active[i]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_voice_start       <= '0;
      o_voice_stop        <= '0;
      wave_sel            <= WAVE_SINE;
      avs.avs_s0_readdata <= '0;
    end else begin
      o_voice_start <= start_vec;
      o_voice_stop  <= stop_vec;
      if (wave_adv) wave_sel <= next_wave(wave_sel);
      if (avs.avs_s0_read)
        avs.avs_s0_readdata <= {14'b0, wave_sel, active_count, 8'(NUM_VOICES)};
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed and randomized checks of voice_allocator at 10 and 4 voices
// against a rule-level allocation model.
module tb_voice_allocator;
  localparam int N0 = 10;
  localparam int N1 = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  voice_allocator_if bus0 ();
  voice_allocator_if bus1 ();

  logic [N0-1:0]   act0, start0, stop0;
  logic [N0*7-1:0] note0;
  logic [N0*8-1:0] vel0;
  logic [1:0]      wave0;
  logic [N1-1:0]   act1, start1, stop1;
  logic [N1*7-1:0] note1;
  logic [N1*8-1:0] vel1;
  logic [1:0]      wave1;

  voice_allocator #(.NUM_VOICES(N0), .NOTE_W(7), .VEL_W(8)) dut0 (
    .clk(clk), .reset(reset), .avs(bus0.slave),
    .o_voice_active(act0), .o_voice_note(note0), .o_voice_velocity(vel0),
    .o_voice_start(start0), .o_voice_stop(stop0), .o_wave_sel(wave0)
  );

  voice_allocator #(.NUM_VOICES(N1), .NOTE_W(7), .VEL_W(8)) dut1 (
    .clk(clk), .reset(reset), .avs(bus1.slave),
    .o_voice_active(act1), .o_voice_note(note1), .o_voice_velocity(vel1),
    .o_voice_start(start1), .o_voice_stop(stop1), .o_wave_sel(wave1)
  );

  int checks = 0;
  int errors = 0;

  int m_act  [2][10];
  int m_note [2][10];
  int m_vel  [2][10];
  int m_age  [2][10];
  int m_wave [2];
  logic [31:0] exp_start, exp_stop;

  function automatic int nv(input int d);
    return (d == 0) ? N0 : N1;
  endfunction

  function automatic logic [31:0] dut_active(input int d);
    return (d == 0) ? 32'(act0) : 32'(act1);
  endfunction
  function automatic logic [31:0] dut_start(input int d);
    return (d == 0) ? 32'(start0) : 32'(start1);
  endfunction
  function automatic logic [31:0] dut_stop(input int d);
    return (d == 0) ? 32'(stop0) : 32'(stop1);
  endfunction
  function automatic logic [6:0] dut_note(input int d, input int v);
    if (d == 0) return note0[v*7 +: 7];
    return note1[v*7 +: 7];
  endfunction
  function automatic logic [7:0] dut_vel(input int d, input int v);
    if (d == 0) return vel0[v*8 +: 8];
    return vel1[v*8 +: 8];
  endfunction
  function automatic logic [1:0] dut_wave(input int d);
    return (d == 0) ? wave0 : wave1;
  endfunction
  function automatic logic dut_wait(input int d);
    return (d == 0) ? bus0.avs_s0_waitrequest : bus1.avs_s0_waitrequest;
  endfunction
  function automatic logic [31:0] dut_rdata(input int d);
    return (d == 0) ? bus0.avs_s0_readdata : bus1.avs_s0_readdata;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic set_write(input int d, input logic w, input logic [31:0] wd);
    if (d == 0) begin bus0.avs_s0_write = w; bus0.avs_s0_writedata = wd; end
    else        begin bus1.avs_s0_write = w; bus1.avs_s0_writedata = wd; end
  endtask

  task automatic set_read(input int d, input logic r);
    if (d == 0) bus0.avs_s0_read = r;
    else        bus1.avs_s0_read = r;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_wave[d] = 0;
      for (int i = 0; i < 10; i++) begin
        m_act[d][i] = 0; m_note[d][i] = 0; m_vel[d][i] = 0; m_age[d][i] = 0;
      end
    end
  endtask

  // Allocation rules: retrigger same note, else first free, else oldest.
  task automatic model_cmd(input int d, input logic [31:0] wd);
    int n = nv(d);
    int note = int'(wd[14:8]);
    int vel = int'(wd[7:0]);
    int t = -1;
    exp_start = '0;
    exp_stop  = '0;
    if (wd[15]) begin
      if (note == 0) begin
        m_wave[d] = (m_wave[d] + 1) % 4;
      end else if (note != 127) begin
        for (int i = 0; i < n; i++) if (t < 0 && m_act[d][i] != 0 && m_note[d][i] == note) t = i;
        for (int i = 0; i < n; i++) if (t < 0 && m_act[d][i] == 0) t = i;
        if (t < 0) begin
          t = 0;
          for (int i = 1; i < n; i++) if (m_age[d][i] > m_age[d][t]) t = i;
        end
        for (int i = 0; i < n; i++)
          if (i != t && m_act[d][i] != 0 && m_age[d][i] < n - 1) m_age[d][i]++;
        m_act[d][t] = 1; m_note[d][t] = note; m_vel[d][t] = vel; m_age[d][t] = 0;
        exp_start[t] = 1'b1;
      end
    end else if (note == 127) begin
      for (int i = 0; i < n; i++)
        if (m_act[d][i] != 0) begin exp_stop[i] = 1'b1; m_act[d][i] = 0; end
    end else if (note != 0) begin
      for (int i = 0; i < n; i++)
        if (m_act[d][i] != 0 && m_note[d][i] == note) begin exp_stop[i] = 1'b1; m_act[d][i] = 0; end
    end
  endtask

  task automatic check_state(input int d, input string tag);
    logic [31:0] m = '0;
    for (int i = 0; i < nv(d); i++) if (m_act[d][i] != 0) m[i] = 1'b1;
    check({tag, "/active"}, 64'(dut_active(d)), 64'(m));
    for (int i = 0; i < nv(d); i++)
      if (m_act[d][i] != 0) begin
        check($sformatf("%s/note%0d", tag, i), 64'(dut_note(d, i)), 64'(m_note[d][i]));
        check($sformatf("%s/vel%0d", tag, i), 64'(dut_vel(d, i)), 64'(m_vel[d][i]));
      end
    check({tag, "/wave"}, 64'(dut_wave(d)), 64'(m_wave[d]));
  endtask

  task automatic do_read(input int d, input string tag);
    int cnt = 0;
    logic [31:0] e;
    for (int i = 0; i < nv(d); i++) if (m_act[d][i] != 0) cnt++;
    e = (32'(m_wave[d]) << 16) | (32'(cnt) << 8) | 32'(nv(d));
    set_read(d, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_read(d, 1'b0);
    check({tag, "/readdata"}, 64'(dut_rdata(d)), 64'(e));
  endtask

  // Called on a negedge; returns on a negedge.
  task automatic do_cmd(input int d, input logic [31:0] wd, input string tag);
    int cyc = 0;
    logic busy_pulse = 1'b0;
    while (dut_wait(d) && cyc < 200) begin @(negedge clk); cyc++; end
    set_write(d, 1'b1, wd);
    @(posedge clk);
    @(negedge clk);
    set_write(d, 1'b0, '0);
    model_cmd(d, wd);
    cyc = 0;
    while (dut_wait(d) && cyc < 200) begin
      if ((dut_start(d) | dut_stop(d)) != 0) busy_pulse = 1'b1;
      cyc++;
      @(negedge clk);
    end
    check({tag, "/wait_cycles"}, 64'(cyc), 64'(nv(d) + 1));
    check({tag, "/pulse_busy"}, 64'(busy_pulse), 64'(0));
    check({tag, "/start"}, 64'(dut_start(d)), 64'(exp_start));
    check({tag, "/stop"}, 64'(dut_stop(d)), 64'(exp_stop));
    @(negedge clk);
    check({tag, "/pulse_len"}, 64'(dut_start(d) | dut_stop(d)), 64'(0));
    check_state(d, tag);
    do_read(d, tag);
  endtask

  task automatic check_cleared(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s%0d/active", tag, d), 64'(dut_active(d)), 64'(0));
      check($sformatf("%s%0d/pulses", tag, d), 64'(dut_start(d) | dut_stop(d)), 64'(0));
      check($sformatf("%s%0d/wait", tag, d), 64'(dut_wait(d)), 64'(0));
      check($sformatf("%s%0d/wave", tag, d), 64'(dut_wave(d)), 64'(0));
      check($sformatf("%s%0d/rdata", tag, d), 64'(dut_rdata(d)), 64'(0));
      for (int i = 0; i < nv(d); i++)
        check($sformatf("%s%0d/nv%0d", tag, d, i), 64'({dut_note(d, i), dut_vel(d, i)}), 64'(0));
    end
  endtask

  initial begin
    logic [31:0] wd, rnd;
    int d, r, note;
    logic pulse_seen;

    reset = 1'b1;
    set_write(0, 1'b0, '0); set_write(1, 1'b0, '0);
    set_read(0, 1'b0); set_read(1, 1'b0);
    model_reset();
    repeat (3) @(negedge clk);
    check_cleared("reset");
    reset = 1'b0;
    @(negedge clk);
    do_read(0, "rst_read0");
    do_read(1, "rst_read1");

    do_cmd(0, 32'h0000_C500, "on69");
    do_cmd(0, 32'h0000_C57F, "on69_retrig");
    for (int k = 0; k < 4; k++) do_cmd(0, 32'h0000_8000, $sformatf("wave%0d", k));
    do_cmd(0, 32'h0000_BC20, "on60");
    do_cmd(0, 32'h0000_BE21, "on62");
    do_cmd(0, 32'h0000_4900, "off73_nomatch");
    do_cmd(0, 32'h0000_7F00, "stop_all");
    do_cmd(0, 32'h0000_FF10, "on127_noop");
    do_cmd(0, 32'h0000_0011, "off0_noop");

    do_cmd(1, 32'h0000_BC01, "n4_on60");
    do_cmd(1, 32'h0000_BE02, "n4_on62");
    do_cmd(1, 32'h0000_C003, "n4_on64");
    do_cmd(1, 32'h0000_C104, "n4_on65");
    do_cmd(1, 32'h0000_C305, "n4_steal67");
    do_cmd(1, 32'hABCD_3C00, "n4_off60_stale");

    do_cmd(0, 32'h0000_B240, "pre_rst_on");
    do_cmd(0, 32'h0000_8000, "pre_rst_wave");
    set_write(0, 1'b1, 32'h0000_B441);
    @(posedge clk);
    @(negedge clk);
    set_write(0, 1'b0, '0);
    repeat (2) @(negedge clk);
    check("midscan/busy", 64'(dut_wait(0)), 64'(1));
    #2 reset = 1'b1;
    #1 model_reset();
    check_cleared("midscan_rst");
    @(negedge clk);
    reset = 1'b0;
    pulse_seen = 1'b0;
    for (int k = 0; k < N0 + 3; k++) begin
      @(negedge clk);
      if ((dut_start(0) | dut_stop(0) | dut_active(0)) != 0) pulse_seen = 1'b1;
    end
    check("midscan/no_pulse", 64'(pulse_seen), 64'(0));

    for (int k = 0; k < 160; k++) begin
      d = k % 2;
      r = $urandom_range(0, 99);
      rnd = $urandom();
      note = 40 + $urandom_range(0, 11);
      wd = {rnd[31:16], 16'h0000};
      wd[7:0] = 8'($urandom_range(0, 255));
      if (r < 55)      begin wd[15] = 1'b1; wd[14:8] = 7'(note); end
      else if (r < 80) begin wd[15] = 1'b0; wd[14:8] = 7'(note); end
      else if (r < 85) begin wd[15] = 1'b0; wd[14:8] = 7'd127; end
      else if (r < 90) begin wd[15] = 1'b1; wd[14:8] = 7'd0; end
      else if (r < 94) begin wd[15] = 1'b1; wd[14:8] = 7'd127; end
      else if (r < 97) begin wd[15] = 1'b0; wd[14:8] = 7'd0; end
      else             begin wd[15] = 1'b1; wd[14:8] = 7'($urandom_range(1, 126)); end
      do_cmd(d, wd, $sformatf("rnd%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
